// File: rtl/ppu_video_pkg.sv
// Shared video types and raster constants for the PPU output path.
// The scanline-dim option of the line doubler is selected with SCANLINE_DIM_EN.
package ppu_video_pkg;

  typedef logic [11:0] rgb12_t;

  localparam int SRC_W    = 256;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int H_TOTAL  = 800;
  localparam int V_TOTAL  = 525;

  // Attributes of a raster position travelling alongside its RAM read
  typedef struct packed {
    logic win;
    logic valid;
  } rd_meta_t;

  // Halve each 4-bit channel of a {R,G,B} pixel
  function automatic rgb12_t dim_rgb(input rgb12_t c);
    return {1'b0, c[11:9], 1'b0, c[7:5], 1'b0, c[3:1]};
  endfunction

endpackage

// File: rtl/line_ram.sv
// Simple dual-port line storage: one write port, one read port with a
// registered (1-cycle) read. Contents are never reset.
module line_ram #(
  parameter int DEPTH = 512,
  parameter int W     = 12,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/line_doubler_buffer.sv
// Ping-pong scanline buffer: stores one source line while the other is replayed
// twice vertically and pixel-doubled horizontally. Define SCANLINE_DIM_EN to dim odd lines.
module line_doubler_buffer #(
  parameter int          SRC_W      = ppu_video_pkg::SRC_W,
  parameter int          H_ACTIVE   = ppu_video_pkg::H_ACTIVE,
  parameter int          V_ACTIVE   = ppu_video_pkg::V_ACTIVE,
  parameter int          X_OFFSET   = 64,
  parameter logic [11:0] BORDER_RGB = 12'hFFF
) (
  input  logic        CLOCK_24,
  input  logic        RESET_N,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sol,
  input  logic [11:0] in_pixel,
  input  logic [9:0]  hpos,
  input  logic [9:0]  vpos,
  output logic [11:0] out_rgb,
  output logic        out_de,
  output logic        underrun,
  output logic        sync_err
);
  import ppu_video_pkg::*;

  localparam int          IW      = $clog2(SRC_W);
  localparam int          STAGES  = 2;
  localparam logic [9:0]  H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0]  X_OFF   = 10'(X_OFFSET);
  localparam logic [9:0]  WIN_END = 10'(X_OFFSET + 2 * SRC_W);

  // ---------------- write side ----------------
  logic [IW-1:0] wr_cnt_q, wr_cnt_d;
  logic          wr_full_q, wr_full_d;
  logic          wr_sel_q, wr_sel_d;
  logic          rd_valid_q, rd_valid_d;
  logic          underrun_q, underrun_d;
  logic          sync_err_q, sync_err_d;

  logic          xfer, last_wr, swap_ev, do_swap;
  logic [IW-1:0] wr_idx;

  assign in_ready = !wr_full_q;
  assign xfer     = in_valid && in_ready;
  assign wr_idx   = in_sol ? '0 : wr_cnt_q;
  // SRC_W is a power of two, so the last slot is all-ones
  assign last_wr  = xfer && !in_sol && (&wr_cnt_q);
  assign swap_ev  = (hpos == '0) && (vpos < V_ACT) && !vpos[0];
  assign do_swap  = swap_ev && (wr_full_q || last_wr);

  always_comb begin
    wr_cnt_d   = wr_cnt_q;
    wr_full_d  = wr_full_q;
    wr_sel_d   = wr_sel_q;
    rd_valid_d = rd_valid_q;
    underrun_d = underrun_q;
    sync_err_d = sync_err_q;
    if (xfer) begin
      if (in_sol) begin
        wr_cnt_d = IW'(1);
        if (wr_cnt_q != '0) sync_err_d = 1'b1;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
        if (last_wr) wr_full_d = 1'b1;
      end
    end
    if (do_swap) begin
      wr_sel_d   = !wr_sel_q;
      wr_full_d  = 1'b0;
      rd_valid_d = 1'b1;
    end else if (swap_ev) begin
      underrun_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_24) begin
    if (!RESET_N) begin
      wr_cnt_q   <= '0;
      wr_full_q  <= 1'b0;
      wr_sel_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      wr_cnt_q   <= wr_cnt_d;
      wr_full_q  <= wr_full_d;
      wr_sel_q   <= wr_sel_d;
      rd_valid_q <= rd_valid_d;
      underrun_q <= underrun_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign underrun = underrun_q;
  assign sync_err = sync_err_q;

  // ---------------- line storage ----------------
  logic          vis, in_win;
  logic [IW-1:0] rd_idx;
  rgb12_t        ram_rdata;

  assign vis    = (hpos < H_ACT) && (vpos < V_ACT);
  assign in_win = (hpos >= X_OFF) && (hpos < WIN_END);
  assign rd_idx = IW'((hpos - X_OFF) >> 1);

  line_ram #(
    .DEPTH (2 * SRC_W),
    .W     (12)
  ) u_line_ram (
    .clk_i   (CLOCK_24),
    .we_i    (xfer),
    .waddr_i ({wr_sel_q, wr_idx}),
    .wdata_i (in_pixel),
    .raddr_i ({!wr_sel_q, rd_idx}),
    .rdata_o (ram_rdata)
  );

  // ---------------- read pipeline ----------------
  logic [STAGES:1] vld_pipe_q;
  rd_meta_t        meta_q;
  rgb12_t          out_rgb_q, out_rgb_d;
`ifdef SCANLINE_DIM_EN
  logic            odd_q;
`endif

  always_comb begin
    if (!vld_pipe_q[1])    out_rgb_d = '0;
    else if (!meta_q.win)  out_rgb_d = BORDER_RGB;
    else if (!meta_q.valid) out_rgb_d = '0;
    else begin
`ifdef SCANLINE_DIM_EN
      out_rgb_d = odd_q ? dim_rgb(ram_rdata) : ram_rdata;
`else
      out_rgb_d = ram_rdata;
`endif
    end
  end

  always_ff @(posedge CLOCK_24) begin
    if (!RESET_N) begin
      vld_pipe_q <= '0;
      meta_q     <= '0;
      out_rgb_q  <= '0;
`ifdef SCANLINE_DIM_EN
      odd_q      <= 1'b0;
`endif
    end else begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], vis};
      meta_q     <= '{win: in_win, valid: rd_valid_q};
      out_rgb_q  <= out_rgb_d;
`ifdef SCANLINE_DIM_EN
      odd_q      <= vpos[0];
`endif
    end
  end

  assign out_rgb = out_rgb_q;
  assign out_de  = vld_pipe_q[STAGES];

endmodule

// File: tb/tb_line_doubler_buffer.sv
// Scoreboard bench for line_doubler_buffer: behavioural model plus a table of
// hand-derived raster spot checks; builds with or without SCANLINE_DIM_EN.
module tb_line_doubler_buffer;
  import ppu_video_pkg::*;

  logic        CLOCK_24 = 1'b0;
  logic        RESET_N  = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_sol   = 1'b0;
  logic [11:0] in_pixel = '0;
  logic [9:0]  hpos     = 10'd700;
  logic [9:0]  vpos     = 10'd500;
  logic        in_ready, out_de, underrun, sync_err;
  logic [11:0] out_rgb;

  always #5 CLOCK_24 = ~CLOCK_24;

  line_doubler_buffer dut (
    .CLOCK_24 (CLOCK_24),
    .RESET_N  (RESET_N),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sol   (in_sol),
    .in_pixel (in_pixel),
    .hpos     (hpos),
    .vpos     (vpos),
    .out_rgb  (out_rgb),
    .out_de   (out_de),
    .underrun (underrun),
    .sync_err (sync_err)
  );

  typedef struct {
    int     h;
    int     v;
    rgb12_t rgb;
    logic   de;
  } exp_t;

  int     n_chk  = 0;
  int     n_fail = 0;
  exp_t   sb_q[$];
  exp_t   tab[18];
  rgb12_t px[SRC_W];

  // reference model state
  rgb12_t m_wr[SRC_W];
  rgb12_t m_disp[SRC_W];
  bit     m_full, m_valid, m_under, m_serr;
  int     m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t exp_of(input int h, input int v);
    exp_t e;
    e.h = h; e.v = v; e.rgb = '0; e.de = 1'b0;
    if (h < H_ACTIVE && v < V_ACTIVE) begin
      e.de = 1'b1;
      if (h >= 64 && h < 64 + 2 * SRC_W) begin
        if (m_valid) e.rgb = m_disp[(h - 64) / 2];
`ifdef SCANLINE_DIM_EN
        if (v % 2 == 1) e.rgb = (e.rgb >> 1) & 12'h777;
`endif
      end else begin
        e.rgb = 12'hFFF;
      end
    end
    return e;
  endfunction

  // One clock: compare what the DUT produced, then apply the next inputs.
  task automatic drive(input int h, input int v, input bit vld, input bit sol, input rgb12_t pix,
                       input bit use_tab, input rgb12_t t_rgb, input bit t_de);
    exp_t e;
    bit   xfer, last, swap;
    @(posedge CLOCK_24); #1;
    if (sb_q.size() >= 2) begin
      e = sb_q.pop_front();
      check($sformatf("rgb h=%0d v=%0d", e.h, e.v), out_rgb, e.rgb);
      check($sformatf("de h=%0d v=%0d", e.h, e.v), out_de, e.de);
    end
    check("in_ready", in_ready, !m_full);
    check("underrun", underrun, m_under);
    check("sync_err", sync_err, m_serr);
    hpos = 10'(h); vpos = 10'(v); in_valid = vld; in_sol = sol; in_pixel = pix;
    xfer = vld && !m_full;
    last = xfer && !sol && (m_cnt == SRC_W - 1);
    swap = (h == 0) && (v < V_ACTIVE) && (v % 2 == 0);
    if (xfer) begin
      m_wr[sol ? 0 : m_cnt] = pix;
      if (sol) begin
        if (m_cnt != 0) m_serr = 1'b1;
        m_cnt = 1;
      end else if (last) begin
        m_cnt = 0;
        m_full = 1'b1;
      end else begin
        m_cnt++;
      end
    end
    if (swap) begin
      if (m_full) begin
        m_disp = m_wr; m_valid = 1'b1; m_full = 1'b0;
      end else begin
        m_under = 1'b1;
      end
    end
    if (use_tab) begin
      e.h = h; e.v = v; e.rgb = t_rgb; e.de = t_de;
      sb_q.push_back(e);
    end else begin
      sb_q.push_back(exp_of(h, v));
    end
  endtask

  task automatic step(input int h, input int v, input bit vld, input bit sol, input rgb12_t pix);
    drive(h, v, vld, sol, pix, 1'b0, 12'h000, 1'b0);
  endtask

  task automatic show(input int v, input int lo, input int hi);
    for (int h = lo; h <= hi; h++) step(h, v, 1'b0, 1'b0, 12'h000);
  endtask

  task automatic stream(input int n, input bit sol);
    for (int i = 0; i < n; i++) step(700, 500, 1'b1, sol && (i == 0), px[i]);
  endtask

  task automatic do_reset();
    RESET_N = 1'b0; in_valid = 1'b0; in_sol = 1'b0; hpos = 10'd100; vpos = 10'd100;
    repeat (3) @(posedge CLOCK_24);
    #1;
    check("rst out_rgb", out_rgb, 12'h000);
    check("rst out_de", out_de, 1'b0);
    check("rst underrun", underrun, 1'b0);
    check("rst sync_err", sync_err, 1'b0);
    check("rst in_ready", in_ready, 1'b1);
    RESET_N = 1'b1;
    sb_q.delete();
    m_full = 1'b0; m_valid = 1'b0; m_under = 1'b0; m_serr = 1'b0; m_cnt = 0;
  endtask

  initial begin
    // line of pixel value = index, displayed on vpos 4/5
    tab[0]  = '{0,   4,   12'hFFF, 1'b1};
    tab[1]  = '{63,  4,   12'hFFF, 1'b1};
    tab[2]  = '{64,  4,   12'h000, 1'b1};
    tab[3]  = '{65,  4,   12'h000, 1'b1};
    tab[4]  = '{66,  4,   12'h001, 1'b1};
    tab[5]  = '{67,  4,   12'h001, 1'b1};
    tab[6]  = '{127, 4,   12'h01F, 1'b1};
    tab[7]  = '{300, 4,   12'h076, 1'b1};
    tab[8]  = '{574, 4,   12'h0FF, 1'b1};
    tab[9]  = '{575, 4,   12'h0FF, 1'b1};
    tab[10] = '{576, 4,   12'hFFF, 1'b1};
    tab[11] = '{639, 4,   12'hFFF, 1'b1};
    tab[12] = '{640, 4,   12'h000, 1'b0};
    tab[13] = '{799, 4,   12'h000, 1'b0};
    tab[14] = '{10,  5,   12'hFFF, 1'b1};
`ifdef SCANLINE_DIM_EN
    tab[15] = '{100, 5,   12'h001, 1'b1};
    tab[16] = '{575, 5,   12'h077, 1'b1};
`else
    tab[15] = '{100, 5,   12'h012, 1'b1};
    tab[16] = '{575, 5,   12'h0FF, 1'b1};
`endif
    tab[17] = '{64,  480, 12'h000, 1'b0};

    do_reset();

    // solid green line shown on lines 0 and 1
    for (int i = 0; i < SRC_W; i++) px[i] = 12'h0F0;
    stream(SRC_W, 1'b1);
    show(0, 0, 659);
    show(1, 0, 659);
    check("underrun after good swap", underrun, 1'b0);

    // no new line at vpos 2: underrun, previous line repeats
    show(2, 0, 659);
    check("underrun set", underrun, 1'b1);
    show(3, 0, 659);

    // index line fills the write buffer; further pixels stall
    for (int i = 0; i < SRC_W; i++) px[i] = 12'(i);
    stream(SRC_W, 1'b1);
    repeat (4) step(700, 500, 1'b1, 1'b0, 12'hBAD);
    check("in_ready low when full", in_ready, 1'b0);
    for (int i = 0; i < 18; i++) begin
      drive(tab[i].h, tab[i].v, 1'b0, 1'b0, 12'h000, 1'b1, tab[i].rgb, tab[i].de);
      if (i == 1) check("in_ready after swap", in_ready, 1'b1);
    end

    // in_sol mid-line restarts the line and flags sync_err
    for (int i = 0; i < SRC_W; i++) px[i] = 12'h555;
    stream(100, 1'b1);
    check("sync_err clear before", sync_err, 1'b0);
    for (int i = 0; i < SRC_W; i++) px[i] = 12'((i * 7 + 3) & 12'hFFF);
    stream(SRC_W, 1'b1);
    check("sync_err set", sync_err, 1'b1);
    show(6, 0, 659);

    // reset mid-line: stickies clear, window shows 0 until the next good swap
    show(7, 0, 300);
    do_reset();
    show(7, 40, 140);

    // last pixel lands in the swap cycle
    for (int i = 0; i < SRC_W; i++) px[i] = 12'(12'h800 + i);
    stream(SRC_W - 1, 1'b1);
    step(0, 8, 1'b1, 1'b0, px[SRC_W-1]);
    step(1, 8, 1'b0, 1'b0, 12'h000);
    check("in_ready after late swap", in_ready, 1'b1);
    show(8, 2, 659);
    show(9, 0, 659);
    check("no underrun on late swap", underrun, 1'b0);

    // light grey line for the scanline-dim path
    for (int i = 0; i < SRC_W; i++) px[i] = 12'hEEE;
    stream(SRC_W, 1'b1);
    show(10, 0, 659);
    show(11, 0, 659);

    repeat (3) step(700, 500, 1'b0, 1'b0, 12'h000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
